rob_multi: RTL and testbench

- Parametrised reorder buffer for the out-of-order RV32I core; the successor to the single-commit ROB.
- Allocates one entry per cycle from ID and accepts N_CDB writeback channels (ALU, LSB, branch, ...).
- Retires up to COMMIT_W oldest ready entries per cycle, serves two operand lookups for dispatch, and raises redirect/flush on a taken/mispredicted control entry.

---
 rtl/rob_multi_pkg.sv | 34 +++
 rtl/rob_multi_commit_sel.sv | 47 ++++
 rtl/rob_multi.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rob_multi.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_multi_pkg.sv
// Shared encodings for the multi-commit reorder buffer: entry types,
// valid/ready constants, default geometry and type-classification helpers.
package rob_multi_pkg;

    typedef enum logic [2:0] {
        TypeReg      = 3'd0,
        TypeLoad     = 3'd1,
        TypeStore    = 3'd2,
        TypePc       = 3'd3,
        TypePcAndReg = 3'd4
    } rob_type_e;

    localparam logic VALID = 1'b1;
    localparam logic READY = 1'b1;

    localparam int ROB_DEPTH_DEFAULT = 16;
    localparam int ROB_TAG_W_DEFAULT = 4;

    // Memory ops are limited to one retirement per cycle.
    function automatic logic is_mem(input rob_type_e t);
        return (t == TypeLoad) || (t == TypeStore);
    endfunction

    // Control entries may carry a redirect.
    function automatic logic is_ctrl(input rob_type_e t);
        return (t == TypePc) || (t == TypePcAndReg);
    endfunction

    // Entry types that write the architectural register file on retire.
    function automatic logic writes_reg(input rob_type_e t);
        return (t == TypeReg) || (t == TypeLoad) || (t == TypePcAndReg);
    endfunction

endpackage

// File: rtl/rob_multi_commit_sel.sv
// Commit lane selector: given the head window (valid/ready/type/jump per lane)
// produce the retire mask, the number of retirements and the redirect lane.
module rob_commit_sel
    import rob_multi_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = 2,
    parameter int LANE_W   = 1
) (
    input  logic                en,
    input  logic [COMMIT_W-1:0] lane_valid,
    input  logic [COMMIT_W-1:0] lane_ready,
    input  rob_type_e           lane_type [COMMIT_W],
    input  logic [COMMIT_W-1:0] lane_jump,
    output logic [COMMIT_W-1:0] retire_mask,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                redir_valid,
    output logic [LANE_W-1:0]   redir_lane
);

    // Walk lanes oldest-first; stop at a gap, after a memory op, or after a taken control entry
    always_comb begin
        logic go;
        retire_mask = '0;
        retire_cnt  = '0;
        redir_valid = 1'b0;
        redir_lane  = '0;
        go          = en;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (go && lane_valid[k] && lane_ready[k]) begin
                retire_mask[k] = 1'b1;
                retire_cnt     = retire_cnt + CNT_W'(1);
                if (is_mem(lane_type[k])) begin
                    go = 1'b0;
                end
                if (is_ctrl(lane_type[k]) && lane_jump[k]) begin
                    redir_valid = 1'b1;
                    redir_lane  = LANE_W'(k);
                    go          = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: one allocation per cycle, N_CDB writeback
// channels, up to COMMIT_W in-order retirements per cycle, two operand lookups,
// and redirect followed by a one-cycle flush on a taken control entry.
// Build option: define ROB_CDB_BYPASS_EN to let lookups forward same-cycle CDB data.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH_DEFAULT,
    parameter int TAG_W    = ROB_TAG_W_DEFAULT,
    parameter int N_CDB    = 3,
    parameter int COMMIT_W = 2,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         alloc_valid,
    input  logic                         alloc_ready,
    input  logic [REG_W-1:0]             alloc_dest,
    input  logic [2:0]                   alloc_type,
    output logic [TAG_W-1:0]             alloc_tag,
    output logic                         full,
    output logic                         empty,
    input  logic [N_CDB-1:0]             cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]       cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]      cdb_data,
    input  logic [N_CDB-1:0]             cdb_jump,
    input  logic [N_CDB*DATA_W-1:0]      cdb_pc,
    input  logic                         q1_valid,
    input  logic [TAG_W-1:0]             q1_tag,
    output logic                         q1_data_valid,
    output logic [DATA_W-1:0]            q1_data,
    input  logic                         q2_valid,
    input  logic [TAG_W-1:0]             q2_tag,
    output logic                         q2_data_valid,
    output logic [DATA_W-1:0]            q2_data,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*REG_W-1:0]    commit_dest,
    output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic                         lsb_commit,
    output logic                         redirect_valid,
    output logic [DATA_W-1:0]            redirect_pc,
    output logic                         flush
);

    localparam int CNT_W  = $clog2(COMMIT_W + 1);
    localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
    localparam int CW     = TAG_W + 1;

    logic [TAG_W-1:0]  head, tail;
    logic [CW-1:0]     count, count_next;
    logic [DEPTH-1:0]  ent_ready;
    logic [DEPTH-1:0]  ent_jump;
    rob_type_e         ent_type [DEPTH];
    logic [REG_W-1:0]  ent_dest [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DATA_W-1:0] ent_pc   [DEPTH];

    logic [TAG_W-1:0]    lane_idx [COMMIT_W];
    logic [COMMIT_W-1:0] lane_valid, lane_ready, lane_jump;
    rob_type_e           lane_type [COMMIT_W];
    logic [COMMIT_W-1:0] retire_mask;
    logic [CNT_W-1:0]    retire_cnt;
    logic                redir_valid;
    logic [LANE_W-1:0]   redir_lane;
    logic                alloc_do, scan_en;

    logic [COMMIT_W-1:0]        commit_valid_d;
    logic [COMMIT_W*REG_W-1:0]  commit_dest_d;
    logic [COMMIT_W*TAG_W-1:0]  commit_tag_d;
    logic [COMMIT_W*DATA_W-1:0] commit_data_d;
    logic                       lsb_d;
    logic [DATA_W-1:0]          redir_pc_d;

    logic [1:0]        q_req, q_hit;
    logic [TAG_W-1:0]  q_tag  [2];
    logic [DATA_W-1:0] q_val  [2];

    assign alloc_tag = tail;
    // Allocations while full are dropped; younger work is squashed during flush.
    assign alloc_do  = alloc_valid && !flush && !full;
    // Nothing retires while a redirect is in flight or the pipe is flushing.
    assign scan_en   = !redirect_valid && !flush;
    assign count_next = count + CW'(alloc_do) - CW'(retire_cnt);

    // Gather the head window seen by the commit selector
    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            lane_idx[k]   = head + TAG_W'(k);
            lane_valid[k] = CW'(k) < count;
            lane_ready[k] = ent_ready[lane_idx[k]];
            lane_type[k]  = ent_type[lane_idx[k]];
            lane_jump[k]  = ent_jump[lane_idx[k]];
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (CNT_W),
        .LANE_W   (LANE_W)
    ) u_commit_sel (
        .en          (scan_en),
        .lane_valid  (lane_valid),
        .lane_ready  (lane_ready),
        .lane_type   (lane_type),
        .lane_jump   (lane_jump),
        .retire_mask (retire_mask),
        .retire_cnt  (retire_cnt),
        .redir_valid (redir_valid),
        .redir_lane  (redir_lane)
    );

    // Build next-cycle commit, memory-retire and redirect values from the retire mask
    always_comb begin
        commit_valid_d = '0;
        commit_dest_d  = '0;
        commit_tag_d   = '0;
        commit_data_d  = '0;
        lsb_d          = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (retire_mask[k]) begin
                if (is_mem(lane_type[k])) begin
                    lsb_d = 1'b1;
                end
                if (writes_reg(lane_type[k])) begin
                    commit_valid_d[k]                  = VALID;
                    commit_dest_d[k*REG_W +: REG_W]    = ent_dest[lane_idx[k]];
                    commit_tag_d[k*TAG_W +: TAG_W]     = lane_idx[k];
                    commit_data_d[k*DATA_W +: DATA_W]  = ent_data[lane_idx[k]];
                end
            end
        end
        redir_pc_d = redir_valid ? ent_pc[lane_idx[redir_lane]] : '0;
    end

    // Operand lookups: stored ready entry first, then (optionally) same-cycle CDB, lowest channel wins
    always_comb begin
        q_req    = {q2_valid, q1_valid};
        q_tag[0] = q1_tag;
        q_tag[1] = q2_tag;
        for (int i = 0; i < 2; i++) begin
            q_hit[i] = 1'b0;
            q_val[i] = '0;
            if (q_req[i]) begin
                if (ent_ready[q_tag[i]]) begin
                    q_hit[i] = 1'b1;
                    q_val[i] = ent_data[q_tag[i]];
                end
`ifdef ROB_CDB_BYPASS_EN
                else begin
                    for (int c = N_CDB - 1; c >= 0; c--) begin
                        if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == q_tag[i])) begin
                            q_hit[i] = 1'b1;
                            q_val[i] = cdb_data[c*DATA_W +: DATA_W];
                        end
                    end
                end
`endif
            end
        end
    end

    assign q1_data_valid = q_hit[0];
    assign q1_data       = q_val[0];
    assign q2_data_valid = q_hit[1];
    assign q2_data       = q_val[1];

    // Entry payload storage: CDB results (lowest channel wins), then the new allocation
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int c = N_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c]) begin
                    ent_data[cdb_tag[c*TAG_W +: TAG_W]] <= cdb_data[c*DATA_W +: DATA_W];
                    ent_jump[cdb_tag[c*TAG_W +: TAG_W]] <= cdb_jump[c];
                    ent_pc[cdb_tag[c*TAG_W +: TAG_W]]   <= cdb_pc[c*DATA_W +: DATA_W];
                end
            end
            if (alloc_do) begin
                ent_type[tail] <= rob_type_e'(alloc_type);
                ent_dest[tail] <= alloc_dest;
                ent_jump[tail] <= 1'b0;
            end
        end
    end

    // Pointers, ready bits, status flags and registered commit/redirect outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_ready      <= '0;
            full           <= 1'b0;
            empty          <= 1'b1;
            commit_valid   <= '0;
            commit_dest    <= '0;
            commit_tag     <= '0;
            commit_data    <= '0;
            lsb_commit     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                ent_ready      <= '0;
                full           <= 1'b0;
                empty          <= 1'b1;
                commit_valid   <= '0;
                commit_dest    <= '0;
                commit_tag     <= '0;
                commit_data    <= '0;
                lsb_commit     <= 1'b0;
                redirect_valid <= 1'b0;
                redirect_pc    <= '0;
                flush          <= 1'b0;
            end else begin
                for (int c = N_CDB - 1; c >= 0; c--) begin
                    if (cdb_valid[c]) begin
                        ent_ready[cdb_tag[c*TAG_W +: TAG_W]] <= READY;
                    end
                end
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (retire_mask[k]) begin
                        ent_ready[lane_idx[k]] <= 1'b0;
                    end
                end
                if (alloc_do) begin
                    ent_ready[tail] <= alloc_ready;
                    tail            <= tail + TAG_W'(1);
                end
                head           <= head + TAG_W'(retire_cnt);
                count          <= count_next;
                full           <= count_next >= CW'(DEPTH - 1);
                empty          <= count_next == '0;
                commit_valid   <= commit_valid_d;
                commit_dest    <= commit_dest_d;
                commit_tag     <= commit_tag_d;
                commit_data    <= commit_data_d;
                lsb_commit     <= lsb_d;
                redirect_valid <= redir_valid;
                redirect_pc    <= redir_pc_d;
                flush          <= redirect_valid;
            end
        end
    end

`ifndef SYNTHESIS
    // Flag allocations that arrive while the buffer reports full
    always_ff @(posedge clk) begin
        if (!rst && rdy && alloc_valid && !flush) begin
            assert (!full) else $error("rob_multi: allocation while full was dropped");
        end
    end
`endif

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a cycle table for in-order commit and
// memory-op limiting, plus hand sequences for redirect/flush, full/wrap,
// lookup forwarding and asynchronous reset.
module tb_rob_multi;
    import rob_multi_pkg::*;

    localparam int TAG_W = 4;
    localparam int N_CDB = 3;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int COMMIT_W = 2;

    logic clk, rst, rdy;
    logic alloc_valid, alloc_ready;
    logic [REG_W-1:0] alloc_dest;
    logic [2:0] alloc_type;
    logic [TAG_W-1:0] alloc_tag;
    logic full, empty;
    logic [N_CDB-1:0] cdb_valid, cdb_jump;
    logic [N_CDB*TAG_W-1:0] cdb_tag;
    logic [N_CDB*DATA_W-1:0] cdb_data, cdb_pc;
    logic q1_valid, q2_valid, q1_data_valid, q2_data_valid;
    logic [TAG_W-1:0] q1_tag, q2_tag;
    logic [DATA_W-1:0] q1_data, q2_data;
    logic [COMMIT_W-1:0] commit_valid;
    logic [COMMIT_W*REG_W-1:0] commit_dest;
    logic [COMMIT_W*TAG_W-1:0] commit_tag;
    logic [COMMIT_W*DATA_W-1:0] commit_data;
    logic lsb_commit, redirect_valid, flush;
    logic [DATA_W-1:0] redirect_pc;

    int passed = 0;
    int total = 0;

    rob_multi dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_dest(alloc_dest), .alloc_type(alloc_type), .alloc_tag(alloc_tag),
        .full(full), .empty(empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_jump(cdb_jump), .cdb_pc(cdb_pc),
        .q1_valid(q1_valid), .q1_tag(q1_tag),
        .q1_data_valid(q1_data_valid), .q1_data(q1_data),
        .q2_valid(q2_valid), .q2_tag(q2_tag),
        .q2_data_valid(q2_data_valid), .q2_data(q2_data),
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_tag(commit_tag), .commit_data(commit_data),
        .lsb_commit(lsb_commit), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        av;
        logic        ar;
        logic [2:0]  at;
        logic [4:0]  ad;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cd;
        logic [3:0]  atag;
        logic [1:0]  ecv;
        logic [7:0]  etag;
        logic [9:0]  edest;
        logic [63:0] edata;
        logic        elsb;
        logic        eempty;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_ready = 1'b0;
        alloc_dest  = '0;
        alloc_type  = '0;
        cdb_valid   = '0;
        cdb_tag     = '0;
        cdb_data    = '0;
        cdb_jump    = '0;
        cdb_pc      = '0;
    endtask

    task automatic set_alloc(input logic [2:0] t, input logic [4:0] d, input logic r);
        alloc_valid = 1'b1;
        alloc_type  = t;
        alloc_dest  = d;
        alloc_ready = r;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] data,
                           input logic jump, input logic [31:0] pc);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = tag;
        cdb_data[ch*DATA_W +: DATA_W] = data;
        cdb_jump[ch] = jump;
        cdb_pc[ch*DATA_W +: DATA_W] = pc;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        rdy = 1'b1;
        q1_valid = 1'b0; q1_tag = '0;
        q2_valid = 1'b0; q2_tag = '0;
        idle_inputs();

        //            av ar at              ad    cv ct     cd            atag  ecv    etag   edest   edata                    elsb  eempty
        vecs[0]  = '{1'b1, 1'b0, TypeReg,   5'd1, 1'b0, 4'd0, 32'h0,  4'd0, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, TypeReg,   5'd2, 1'b0, 4'd0, 32'h0,  4'd1, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, TypeReg,   5'd3, 1'b0, 4'd0, 32'h0,  4'd2, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b1, 4'd2, 32'h22, 4'd3, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b1, 4'd1, 32'h11, 4'd3, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b1, 4'd0, 32'h10, 4'd3, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd3, 2'b11, 8'h10, 10'h041, 64'h00000011_00000010,    1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd3, 2'b01, 8'h02, 10'h003, 64'h00000000_00000022,    1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd3, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, TypeLoad,  5'd5, 1'b0, 4'd0, 32'h0,  4'd3, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, TypeStore, 5'd0, 1'b0, 4'd0, 32'h0,  4'd4, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b1, 4'd3, 32'h33, 4'd5, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd5, 2'b01, 8'h03, 10'h005, 64'h00000000_00000033,    1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd5, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, TypeReg,   5'd0, 1'b0, 4'd0, 32'h0,  4'd5, 2'b00, 8'h00, 10'h000, 64'h0,                    1'b0, 1'b1};

        // reset state
        do_reset();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);

        // in-order commit and one memory op per cycle
        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            if (vecs[i].av) set_alloc(vecs[i].at, vecs[i].ad, vecs[i].ar);
            if (vecs[i].cv) set_cdb(0, vecs[i].ct, vecs[i].cd, 1'b0, 32'h0);
            #1;
            chk($sformatf("v%0d_alloc_tag", i), 64'(alloc_tag), 64'(vecs[i].atag));
            tick();
            chk($sformatf("v%0d_commit_valid", i), 64'(commit_valid), 64'(vecs[i].ecv));
            chk($sformatf("v%0d_commit_tag", i), 64'(commit_tag), 64'(vecs[i].etag));
            chk($sformatf("v%0d_commit_dest", i), 64'(commit_dest), 64'(vecs[i].edest));
            chk($sformatf("v%0d_commit_data", i), commit_data, vecs[i].edata);
            chk($sformatf("v%0d_lsb_commit", i), 64'(lsb_commit), 64'(vecs[i].elsb));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].eempty));
        end

        // redirect then flush; younger ready entries never commit
        do_reset();
        set_alloc(TypePc, 5'd0, 1'b0); tick();
        set_alloc(TypeReg, 5'd1, 1'b1); tick();
        set_alloc(TypeReg, 5'd2, 1'b1); tick();
        idle_inputs();
        set_cdb(2, 4'd0, 32'h0, 1'b1, 32'h100);
        tick();
        chk("br_no_early_redirect", 64'(redirect_valid), 64'd0);
        chk("br_no_early_commit", 64'(commit_valid), 64'd0);
        idle_inputs();
        tick();
        chk("br_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("br_redirect_pc", 64'(redirect_pc), 64'h100);
        chk("br_commit_none", 64'(commit_valid), 64'd0);
        chk("br_flush_not_yet", 64'(flush), 64'd0);
        tick();
        chk("br_redirect_drop", 64'(redirect_valid), 64'd0);
        chk("br_flush", 64'(flush), 64'd1);
        chk("br_commit_during_redirect", 64'(commit_valid), 64'd0);
        tick();
        chk("br_flush_done", 64'(flush), 64'd0);
        chk("br_empty", 64'(empty), 64'd1);
        chk("br_commit_during_flush", 64'(commit_valid), 64'd0);
        chk("br_alloc_tag", 64'(alloc_tag), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("br_post_commit%0d", i), 64'(commit_valid), 64'd0);
        end

        // fill until full, retire two, allocate across the wrap point
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_alloc(TypeReg, 5'(i + 1), 1'b0);
            #1;
            chk($sformatf("fill_alloc_tag%0d", i), 64'(alloc_tag), 64'(i));
            tick();
        end
        chk("fill14_full", 64'(full), 64'd0);
        set_alloc(TypeReg, 5'd15, 1'b0);
        #1;
        chk("fill15_alloc_tag", 64'(alloc_tag), 64'd14);
        tick();
        chk("fill15_full", 64'(full), 64'd1);
        idle_inputs();
        set_cdb(0, 4'd0, 32'hA0, 1'b0, 32'h0);
        set_cdb(1, 4'd1, 32'hA1, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();
        chk("wrap_commit_valid", 64'(commit_valid), 64'd3);
        chk("wrap_commit_tag", 64'(commit_tag), 64'h10);
        chk("wrap_full_clear", 64'(full), 64'd0);
        set_alloc(TypeReg, 5'd16, 1'b0);
        #1;
        chk("wrap_alloc_tag15", 64'(alloc_tag), 64'd15);
        tick();
        chk("wrap_alloc_tag0", 64'(alloc_tag), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("wrap_alloc_tag1", 64'(alloc_tag), 64'd1);
        chk("wrap_full_again", 64'(full), 64'd1);

        // lookup with same-cycle CDB on channel 2, then stored value
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(TypeReg, 5'(i + 1), 1'b0);
            tick();
        end
        idle_inputs();
        q1_valid = 1'b1; q1_tag = 4'd5;
        q2_valid = 1'b1; q2_tag = 4'd3;
        set_cdb(2, 4'd5, 32'hDEAD, 1'b0, 32'h0);
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("q1_bypass_valid", 64'(q1_data_valid), 64'd1);
        chk("q1_bypass_data", 64'(q1_data), 64'hDEAD);
`else
        chk("q1_nobypass_valid", 64'(q1_data_valid), 64'd0);
        chk("q1_nobypass_data", 64'(q1_data), 64'd0);
`endif
        chk("q2_notready_valid", 64'(q2_data_valid), 64'd0);
        chk("q2_notready_data", 64'(q2_data), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk("q1_stored_valid", 64'(q1_data_valid), 64'd1);
        chk("q1_stored_data", 64'(q1_data), 64'hDEAD);
        q1_valid = 1'b0;
        #1;
        chk("q1_noreq_valid", 64'(q1_data_valid), 64'd0);
        chk("q1_noreq_data", 64'(q1_data), 64'd0);
        q2_valid = 1'b0;

        // asynchronous reset with live entries and commits in progress
        set_cdb(0, 4'd0, 32'h50, 1'b0, 32'h0);
        set_cdb(1, 4'd1, 32'h51, 1'b0, 32'h0);
        tick();
        idle_inputs();
        tick();
        chk("ar_pre_commit_valid", 64'(commit_valid), 64'd3);
        chk("ar_pre_commit_data", commit_data, 64'h00000051_00000050);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_commit_valid", 64'(commit_valid), 64'd0);
        chk("ar_commit_data", commit_data, 64'd0);
        chk("ar_empty", 64'(empty), 64'd1);
        chk("ar_full", 64'(full), 64'd0);
        chk("ar_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("ar_redirect", 64'(redirect_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ar_post_commit%0d", i), 64'(commit_valid), 64'd0);
            chk($sformatf("ar_post_empty%0d", i), 64'(empty), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
